reg_bank_p: RTL and testbench
=============================

Name: reg_bank_p

Overview:
- Parametrised next-generation register bank feeding the two ALU operand buses (outA/outB).
- Generalised in data width and depth.
- Adds per-write modes: full word, low half, high half, accumulate.
- Adds a multi-cycle clear sweep FSM and registered, enable-gated read ports with constant injection.

Parameters:
- DATA_W, 64, register and bus width in bits; must be even.
- NREGS, 16, number of registers; power of two, at least 2.
- ADDR_W, $clog2(NREGS), select width.
- CNST_A, 64'd1, value driven on outA when cnstA is set; truncated to DATA_W.
- CNST_B, 64'd0, value driven on outB when cnstB is set; truncated to DATA_W.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- regwen  input  1  write request, sampled each rising edge.
- selwreg  input  ADDR_W  write address.
- endwreg  input  2  write mode: 00 full, 01 low half, 10 high half, 11 accumulate.
- inA  input  DATA_W  write data.
- seloutA  input  ADDR_W  read address, port A.
- seloutB  input  ADDR_W  read address, port B.
- enrregA  input  1  port A output register load enable.
- enrregB  input  1  port B output register load enable.
- cnstA  input  1  load CNST_A into outA instead of a register value.
- cnstB  input  1  load CNST_B into outB instead of a register value.
- clrstart  input  1  start clear sweep (pulse).
- clrbusy  output  1  high while the sweep is active.
- outA  output  DATA_W  registered read data, port A.
- outB  output  DATA_W  registered read data, port B.

Behaviour:
- Reset (synchronous, active-high):
  - All NREGS registers become 0.
  - outA = 0, outB = 0, clrbusy = 0.
  - FSM goes to IDLE; sweep counter = 0.
  - Reset overrides every other input in the same cycle, including mid-sweep.
- Write (regwen=1, FSM=IDLE) to reg[selwreg] at the rising edge, by mode:
  - 00: reg <= inA.
  - 01: reg[DATA_W/2-1:0] <= inA[DATA_W/2-1:0]; upper half kept.
  - 10: reg[DATA_W-1:DATA_W/2] <= inA[DATA_W/2-1:0]; lower half kept.
  - 11: reg <= reg + inA, modulo 2^DATA_W; carry discarded, no flag.
- Read ports (A and B are independent and identical):
  - If enrregX=1: outX <= cnstX ? CNST_X : value(reg[seloutX]).
  - If enrregX=0: outX holds.
  - Latency is 1 clock from select to outX.
  - Both ports may select the same address.
- Simultaneous write and read of the same address: see Optional Feature.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clrstart=1. Counter=0, clrbusy=1 from the next cycle.
  - SWEEP: each cycle reg[counter] <= 0 and counter increments. After zeroing reg[NREGS-1], return to IDLE with clrbusy=0 the following cycle.
  - A sweep therefore takes exactly NREGS cycles.
- During SWEEP:
  - regwen is ignored and the write is dropped, not queued.
  - clrstart is ignored.
  - Reads continue and return current contents (already-cleared entries read 0).
- clrstart and regwen in the same IDLE cycle: the write commits, then the sweep starts and later clears it.

Optional Feature:
- Macro: REG_BANK_FWD_EN.
- Defined: a same-cycle write to the register being read is forwarded. outX is loaded with the post-write value, i.e. the value after the mode is applied, including accumulate results. cnstX still has priority.
- Undefined: outX is loaded with the pre-write value; the new value is visible from the next read.
- Sweep zeroing is never forwarded in either build.

Test Plan:
- Write i*400 to reg i for i=0..15 (mode 00); then read seloutA=i with enrregA=1 -> outA = i*400 one cycle later, for every i.
- reg 3 = 64'h1111_2222_3333_4444; mode 01 with inA=64'hAAAA_BBBB -> reg 3 = 64'h1111_2222_AAAA_BBBB. Then mode 10 with inA=64'hCCCC_DDDD -> reg 3 = 64'hCCCC_DDDD_AAAA_BBBB.
- reg 5 = 64'hFFFF_FFFF_FFFF_FFFF; mode 11 with inA=2 -> reg 5 = 1 (wrap).
- cnstA=1, cnstB=1, enrregA=enrregB=1 -> outA = 1, outB = 0.
  - Then enrregA=0 with reg changes -> outA holds.
- Fill all 16 regs; pulse clrstart; regwen=1 to reg 2 during the sweep:
  - clrbusy high exactly 16 cycles.
  - Write dropped.
  - All reads return 0 afterwards.
  - Assert reset at sweep cycle 7 -> IDLE next cycle, clrbusy=0, all regs 0.
- Same-cycle write of 500 to reg 4 with seloutA=4 (old value 400): outA = 500 with REG_BANK_FWD_EN, 400 without.

Source files
------------

// File: rtl/reg_bank_p.sv
// Parametrised dual-read register bank with write modes, a clear-sweep FSM and
// registered, enable-gated read ports. Define REG_BANK_FWD_EN to forward same-cycle writes to reads.
module reg_bank_p #(
    parameter int          DATA_W = 64,
    parameter int          NREGS  = 16,
    parameter int          ADDR_W = $clog2(NREGS),
    parameter logic [63:0] CNST_A = 64'd1,
    parameter logic [63:0] CNST_B = 64'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              regwen,
    input  logic [ADDR_W-1:0] selwreg,
    input  logic [1:0]        endwreg,
    input  logic [DATA_W-1:0] inA,
    input  logic [ADDR_W-1:0] seloutA,
    input  logic [ADDR_W-1:0] seloutB,
    input  logic              enrregA,
    input  logic              enrregB,
    input  logic              cnstA,
    input  logic              cnstB,
    input  logic              clrstart,
    output logic              clrbusy,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB
);
    localparam int                HALF_W   = DATA_W / 2;
    localparam logic [DATA_W-1:0] CONST_A  = DATA_W'(CNST_A);
    localparam logic [DATA_W-1:0] CONST_B  = DATA_W'(CNST_B);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                clrbusy_reg;
    logic [DATA_W-1:0]   out_a_reg;
    logic [DATA_W-1:0]   out_b_reg;
    logic [DATA_W-1:0]   regs_reg [NREGS];

    logic                wr_en;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   wr_val;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic [NREGS-1:0]    wr_hit;
    logic [NREGS-1:0]    clr_hit;

    // Writes are dropped (not queued) while the sweep owns the array.
    assign wr_en   = regwen && (state_reg == IDLE);
    assign cur_val = regs_reg[selwreg];

    always_comb begin
        wr_val = inA;
        case (endwreg)
            2'b00: wr_val = inA;
            2'b01: wr_val = {cur_val[DATA_W-1:HALF_W], inA[HALF_W-1:0]};
            2'b10: wr_val = {inA[HALF_W-1:0], cur_val[HALF_W-1:0]};
            2'b11: wr_val = cur_val + inA;
            default: wr_val = inA;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_decode
            assign wr_hit[gi]  = wr_en && (selwreg == ADDR_W'(gi));
            assign clr_hit[gi] = (state_reg == SWEEP) && (cnt_reg == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clr_hit[i])
                    regs_reg[i] <= '0;
                else if (wr_hit[i])
                    regs_reg[i] <= wr_val;
            end
        end
    end

`ifdef REG_BANK_FWD_EN
    // Only real writes forward; sweep zeroing is never visible early.
    assign rd_a = (wr_en && (selwreg == seloutA)) ? wr_val : regs_reg[seloutA];
    assign rd_b = (wr_en && (selwreg == seloutB)) ? wr_val : regs_reg[seloutB];
`else
    assign rd_a = regs_reg[seloutA];
    assign rd_b = regs_reg[seloutB];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_a_reg <= '0;
            out_b_reg <= '0;
        end else begin
            if (enrregA) out_a_reg <= cnstA ? CONST_A : rd_a;
            if (enrregB) out_b_reg <= cnstB ? CONST_B : rd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            clrbusy_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clrstart) begin
                        state_reg   <= SWEEP;
                        cnt_reg     <= '0;
                        clrbusy_reg <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        clrbusy_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    clrbusy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clrbusy = clrbusy_reg;
    assign outA    = out_a_reg;
    assign outB    = out_b_reg;

endmodule

// File: tb/tb_reg_bank_p.sv
// Testbench for reg_bank_p: directed scenarios plus random traffic against a
// behavioural model of the register contents, read ports and clear sweep.
module tb_reg_bank_p;
    localparam int DW = 64;
    localparam int NR = 16;
    localparam int AW = 4;
`ifdef REG_BANK_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, regwen, enrregA, enrregB, cnstA, cnstB, clrstart, clrbusy;
    logic [AW-1:0] selwreg, seloutA, seloutB;
    logic [1:0]    endwreg;
    logic [DW-1:0] inA, outA, outB;

    always #5 clock = ~clock;

    reg_bank_p dut (
        .clock(clock), .reset(reset), .regwen(regwen), .selwreg(selwreg),
        .endwreg(endwreg), .inA(inA), .seloutA(seloutA), .seloutB(seloutB),
        .enrregA(enrregA), .enrregB(enrregB), .cnstA(cnstA), .cnstB(cnstB),
        .clrstart(clrstart), .clrbusy(clrbusy), .outA(outA), .outB(outB)
    );

    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_a, m_b;
    int            sweep_left;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] apply_mode(input logic [DW-1:0] old, input logic [1:0] mode,
                                                 input logic [DW-1:0] data);
        logic [DW-1:0] lo_mask;
        lo_mask = 64'h0000_0000_FFFF_FFFF;
        case (mode)
            2'd0:    return data;
            2'd1:    return (old & ~lo_mask) | (data & lo_mask);
            2'd2:    return (old & lo_mask) | ((data & lo_mask) << 32);
            default: return old + data;
        endcase
    endfunction

    // One clock: predict from current inputs, clock the DUT, compare all outputs.
    task automatic tick();
        logic [DW-1:0] pre [NR];
        logic [DW-1:0] nv;
        bit            wr;
        pre = m_regs;
        if (reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; sweep_left = 0;
        end else begin
            wr = regwen && (sweep_left == 0);
            nv = apply_mode(pre[selwreg], endwreg, inA);
            if (enrregA) m_a = cnstA ? 64'd1 : ((FWD && wr && seloutA == selwreg) ? nv : pre[seloutA]);
            if (enrregB) m_b = cnstB ? 64'd0 : ((FWD && wr && seloutB == selwreg) ? nv : pre[seloutB]);
            if (wr) m_regs[selwreg] = nv;
            if (sweep_left > 0) begin
                m_regs[NR - sweep_left] = '0;
                sweep_left--;
            end else if (clrstart) begin
                sweep_left = NR;
            end
        end
        @(posedge clock);
        #1;
        check_val("outA", outA, m_a);
        check_val("outB", outB, m_b);
        check_val("clrbusy", 64'(clrbusy), 64'(sweep_left > 0));
    endtask

    task automatic idle_inputs();
        reset = 0; regwen = 0; selwreg = '0; endwreg = '0; inA = '0;
        seloutA = '0; seloutB = '0; enrregA = 0; enrregB = 0;
        cnstA = 0; cnstB = 0; clrstart = 0;
    endtask

    task automatic wr(input int addr, input logic [1:0] mode, input logic [DW-1:0] data);
        regwen = 1; selwreg = AW'(addr); endwreg = mode; inA = data;
        tick();
        regwen = 0;
    endtask

    task automatic rd(input int addr);
        seloutA = AW'(addr); seloutB = AW'(NR - 1 - addr); enrregA = 1; enrregB = 1;
        tick();
        enrregA = 0; enrregB = 0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < NR; i++) begin
            rd(i);
            check_val(tag, outA, 64'd0);
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < NR; i++) wr(i, 2'd0, {$urandom, $urandom} | 64'd1);
    endtask

    initial begin
        int busy_cycles;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        read_all_zero("reset_zero");

        for (int i = 0; i < NR; i++) wr(i, 2'd0, DW'(i * 400));
        for (int i = 0; i < NR; i++) begin
            rd(i);
            check_val("rd_i400", outA, DW'(i * 400));
        end

        wr(3, 2'd0, 64'h1111_2222_3333_4444);
        wr(3, 2'd1, 64'hAAAA_BBBB);
        rd(3);
        check_val("mode_low", outA, 64'h1111_2222_AAAA_BBBB);
        wr(3, 2'd2, 64'hCCCC_DDDD);
        rd(3);
        check_val("mode_high", outA, 64'hCCCC_DDDD_AAAA_BBBB);

        wr(5, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(5, 2'd3, 64'd2);
        rd(5);
        check_val("acc_wrap", outA, 64'd1);

        cnstA = 1; cnstB = 1; enrregA = 1; enrregB = 1; seloutA = 4'd5; seloutB = 4'd5;
        tick();
        check_val("cnst_a", outA, 64'd1);
        check_val("cnst_b", outB, 64'd0);
        cnstA = 0; cnstB = 0; enrregA = 0; enrregB = 0;
        wr(5, 2'd0, 64'h1234);
        tick();
        check_val("hold_a", outA, 64'd1);

        fill_all();
        clrstart = 1;
        tick();
        clrstart = 0;
        busy_cycles = clrbusy ? 1 : 0;
        for (int j = 0; j < 40 && clrbusy; j++) begin
            if (j == 10) begin regwen = 1; selwreg = 4'd2; endwreg = 2'd0; inA = 64'd777; end
            tick();
            regwen = 0;
            if (clrbusy) busy_cycles++;
        end
        check_val("busy_len", 64'(busy_cycles), 64'd16);
        rd(2);
        check_val("drop_wr", outA, 64'd0);
        read_all_zero("sweep_zero");

        fill_all();
        clrstart = 1;
        tick();
        clrstart = 0;
        for (int j = 0; j < 7; j++) tick();
        reset = 1;
        tick();
        check_val("rst_busy", 64'(clrbusy), 64'd0);
        reset = 0;
        read_all_zero("rst_mid_zero");

        wr(4, 2'd0, 64'd400);
        regwen = 1; selwreg = 4'd4; endwreg = 2'd0; inA = 64'd500; seloutA = 4'd4; enrregA = 1;
        tick();
        regwen = 0; enrregA = 0;
        check_val("fwd", outA, FWD ? 64'd500 : 64'd400);

        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            clrstart = ($urandom_range(0, 59) == 0);
            regwen   = $urandom_range(0, 1);
            selwreg  = AW'($urandom);
            endwreg  = 2'($urandom);
            inA      = {$urandom, $urandom};
            seloutA  = ($urandom_range(0, 3) == 0) ? selwreg : AW'($urandom);
            seloutB  = ($urandom_range(0, 3) == 0) ? selwreg : AW'($urandom);
            enrregA  = ($urandom_range(0, 3) != 0);
            enrregB  = ($urandom_range(0, 3) != 0);
            cnstA    = ($urandom_range(0, 7) == 0);
            cnstB    = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
